gh_event_logger: RTL and testbench
==================================

Name: gh_event_logger

Overview:
Downstream consumer of the g/h pair produced by the mode-clocked g/h generator stage. Samples g and h every clk and detects g rise, g fall and h rise. Stamps each detected event with a free-running cycle counter and buffers the records in a show-ahead FIFO. Records drain over a valid/ready interface to the bench scoreboard or trace unit. Overflow is reported through a sticky flag and a saturating drop counter.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
TS_W, 16, timestamp width; counter wraps modulo 2^TS_W
DROP_W, 8, drop counter width; saturates at 2^DROP_W-1

Ports:
clk  input  1  sole clock; all state on posedge clk
rst  input  1  asynchronous, active-high reset
en  input  1  1 = event capture enabled; edge history tracks g/h regardless
g  input  1  g output of upstream stage, synchronous to clk
h  input  1  h output of upstream stage, synchronous to clk
evt_valid  output  1  FIFO head record present
evt_ready  input  1  consumer accepts head this cycle
evt_mask  output  3  head event mask {h_rise, g_fall, g_rise}
evt_ts  output  TS_W  head timestamp
level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
ovf  output  1  sticky; set when a record is dropped
drop_cnt  output  DROP_W  records dropped since reset/clear, saturating
clr_ovf  input  1  synchronous clear of ovf and drop_cnt

Behaviour:
- Reset (async assert, rst=1): g_q=0, h_q=0, ts=0, FIFO empty. evt_valid=0, level=0, ovf=0, drop_cnt=0. evt_mask=0 and evt_ts=0 while the FIFO is empty.
- ts increments every clk edge while rst=0, independent of en. Wrap: 2^TS_W-1 -> 0.
- Edge detect is combinational against registered history:
  - g_rise = g & ~g_q
  - g_fall = ~g & g_q
  - h_rise = h & ~h_q
  - g_q <= g and h_q <= h every edge.
- Record: mask = {h_rise, g_fall, g_rise}, ts = ts value before that edge's increment. Simultaneous events in one cycle produce one record with multiple mask bits set, never multiple records.
- push = en & (mask != 0).
- pop = evt_valid & evt_ready. evt_ready while evt_valid=0 has no effect.
- Latency: an event sampled at edge N is written at edge N. evt_valid rises in the cycle after edge N if the FIFO was empty. No bypass.
- Show-ahead FIFO: evt_mask/evt_ts always reflect the head. Head is stable while evt_valid=1 and evt_ready=0.
- Full (level=DEPTH):
  - push with pop in the same cycle: push accepted, level unchanged.
  - push without pop: record dropped, ovf <= 1, drop_cnt <= drop_cnt+1 (saturating).
- Empty with push: level -> 1. Push and pop never bypass on empty.
- clr_ovf=1: ovf <= 0, drop_cnt <= 0. If a drop occurs in the same cycle, the drop wins: ovf=1, drop_cnt=1.
- en=0: no pushes, and any edge in that cycle is lost. The FIFO still drains. History keeps updating, so re-enabling never replays a stale edge.
- Reset mid-operation: all contents are discarded immediately. The first cycle after release treats g_q=h_q=0, so a g already high records g_rise.
- Pointers use a log2(DEPTH)+1 wrap bit. level is derived from the pointer difference.

Decomposition:
- Package gh_evt_pkg holds:
  - MASK_W=3
  - bit indices G_RISE=0, G_FALL=1, H_RISE=2
  - typedef gh_evt_mask_t (logic [2:0])
  - parameterised struct-like record packing {mask, ts}
- Sub-module gh_evt_fifo: a generic show-ahead synchronous FIFO with DEPTH and WIDTH parameters and push, pop, full, empty and level signals. Drop and overflow logic stays in the top module.

Test Plan:
- Reset, en=1, g 0->1 at cycle 5 (ts=5), evt_ready=1 -> one record at cycle 6: mask=3'b001, ts=5. level returns to 0.
- g=1 and h=1 together at ts=10, g falls at ts=12 -> records {3'b101, 10} then {3'b010, 12}, in order.
- evt_ready=0, 9 single-bit events at DEPTH=8 -> level=8, ovf=1, drop_cnt=1. The 9th is lost, and draining returns the first 8 records unchanged.
- Full FIFO, push and pop in the same cycle -> level stays 8, ovf unchanged, new record at the tail.
- drop_cnt=255 (DROP_W=8) plus a further drop -> drop_cnt stays 255. clr_ovf in the same cycle as a drop -> ovf=1, drop_cnt=1.
- en=0 across a g rise, then en=1 with g steady -> no record. rst pulse with level=5 -> level=0 and evt_valid=0 immediately (async).

Source files
------------

// File: rtl/gh_evt_pkg.sv
// Shared definitions for the g/h event logger.
// A record is packed as {mask, ts}: the event mask occupies the MSBs and the
// timestamp the LSBs, so the record width is MASK_W + TS_W.
package gh_evt_pkg;

    localparam int unsigned MASK_W = 3;

    // Bit positions inside the event mask
    localparam int unsigned G_RISE = 0;
    localparam int unsigned G_FALL = 1;
    localparam int unsigned H_RISE = 2;

    typedef logic [MASK_W-1:0] gh_evt_mask_t;

    // Width of one packed {mask, ts} record for a given timestamp width
    function automatic int unsigned gh_evt_rec_w(input int unsigned ts_w);
        return MASK_W + ts_w;
    endfunction

endpackage

// File: rtl/gh_evt_fifo.sv
// Generic show-ahead synchronous FIFO.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (empties the FIFO)
//   push_i     write din_i at the tail (ignored when full unless pop_i)
//   pop_i      advance the head (ignored when empty)
//   din_i      write data
//   dout_o     head entry, valid whenever empty_o = 0
//   full_o     occupancy = DEPTH
//   empty_o    occupancy = 0
//   level_o    occupancy 0..DEPTH
module gh_evt_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    // Pointers carry an extra wrap bit: equal pointers mean empty, equal
    // indices with differing wrap bits mean full.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o = wr_q - rd_q;
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    // When full, a simultaneous pop frees the slot being written
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + PTR_ONE;
        if (do_pop)  rd_d = rd_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/gh_event_logger.sv
// Timestamped g/h edge logger.
// Detects g rise, g fall and h rise against the previous cycle's g/h, stamps
// each cycle with events using a free-running counter, and queues the record
// in a show-ahead FIFO drained over valid/ready. Records that arrive while the
// FIFO is full (and not popping) are dropped and counted.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             capture enable (edge history updates regardless)
//   g, h           upstream signals, synchronous to clk
//   evt_valid      head record present
//   evt_ready      consumer accepts head this cycle
//   evt_mask       head mask {h_rise, g_fall, g_rise}, 0 when empty
//   evt_ts         head timestamp, 0 when empty
//   level          FIFO occupancy 0..DEPTH
//   ovf            sticky drop flag
//   drop_cnt       saturating drop count
//   clr_ovf        synchronous clear of ovf/drop_cnt (a same-cycle drop wins)
module gh_event_logger
    import gh_evt_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       g,
    input  logic                       h,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [MASK_W-1:0]          evt_mask,
    output logic [TS_W-1:0]            evt_ts,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic [DROP_W-1:0]          drop_cnt,
    input  logic                       clr_ovf
);

    localparam int unsigned REC_W = gh_evt_rec_w(TS_W);
    localparam logic [TS_W-1:0]   TS_ONE   = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    logic              g_q, h_q;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    gh_evt_mask_t      evt_now;
    logic              push, pop, drop;
    logic              fifo_full, fifo_empty;
    logic [REC_W-1:0]  head;

    always_comb begin
        evt_now         = '0;
        evt_now[G_RISE] = g & ~g_q;
        evt_now[G_FALL] = ~g & g_q;
        evt_now[H_RISE] = h & ~h_q;
    end

    assign push = en & (evt_now != '0);
    assign pop  = ~fifo_empty & evt_ready;
    assign drop = push & fifo_full & ~pop;
    assign ts_d = ts_q + TS_ONE;

    // Clear is applied first so a same-cycle drop overrides it, leaving 1
    always_comb begin
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + DROP_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q        <= 1'b0;
            h_q        <= 1'b0;
            ts_q       <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            g_q        <= g;
            h_q        <= h;
            ts_q       <= ts_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    gh_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({evt_now, ts_q}),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign evt_valid          = ~fifo_empty;
    assign {evt_mask, evt_ts} = fifo_empty ? '0 : head;
    assign ovf                = ovf_q;
    assign drop_cnt           = drop_cnt_q;

endmodule

// File: tb/tb_gh_event_logger.sv
module tb_gh_event_logger;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TS_W   = 16;
    localparam int unsigned DROP_W = 8;

    logic                   clk = 1'b0;
    logic                   rst, en, g, h, evt_ready, clr_ovf;
    logic                   evt_valid, ovf;
    logic [2:0]             evt_mask;
    logic [TS_W-1:0]        evt_ts;
    logic [$clog2(DEPTH):0] level;
    logic [DROP_W-1:0]      drop_cnt;

    typedef struct packed {
        logic [2:0]      m;
        logic [TS_W-1:0] t;
    } rec_t;

    rec_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   tb_ts = 0;
    logic gv;

    gh_event_logger #(
        .DEPTH  (DEPTH),
        .TS_W   (TS_W),
        .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .g         (g),
        .h         (h),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_mask  (evt_mask),
        .evt_ts    (evt_ts),
        .level     (level),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    // Bench-side timestamp: number of rising edges seen since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts = 0;
        else     tb_ts = tb_ts + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive inputs for the next edge; a nonzero mask queues the expected record
    task automatic step(input logic en_v, input logic g_v, input logic h_v, input logic [2:0] m);
        en = en_v;
        g  = g_v;
        h  = h_v;
        if (m != 3'b000) exp_q.push_back('{m: m, t: tb_ts[TS_W-1:0]});
        tick();
    endtask

    // Monitor: compare every accepted head against the scoreboard
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            vectors = vectors + 1;
            if (exp_q.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL unexpected_record: got mask=%b ts=%0d expected none", evt_mask, evt_ts);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                if (evt_mask !== e.m || evt_ts !== e.t) begin
                    miscompares = miscompares + 1;
                    $display("FAIL record: got mask=%b ts=%0d expected mask=%b ts=%0d",
                             evt_mask, evt_ts, e.m, e.t);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; g = 1'b0; h = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_mask", evt_mask, 0);
        chk("rst_ts", evt_ts, 0);
        rst = 1'b0;

        // Single g rise at ts=5
        evt_ready = 1'b1;
        while (tb_ts < 5) step(1, 0, 0, 3'b000);
        step(1, 1, 0, 3'b001);
        chk("t1_valid", evt_valid, 1);
        chk("t1_head_ts", evt_ts, 5);
        step(1, 1, 0, 3'b000);
        step(1, 1, 0, 3'b000);
        chk("t1_level", level, 0);

        // g and h rise together at ts=10, g falls at ts=12
        step(0, 0, 0, 3'b000);
        while (tb_ts < 10) step(1, 0, 0, 3'b000);
        step(1, 1, 1, 3'b101);
        step(1, 1, 1, 3'b000);
        step(1, 0, 1, 3'b010);
        repeat (3) step(1, 0, 1, 3'b000);
        chk("t2_level", level, 0);

        // Nine events with no consumer: eight kept, ninth dropped
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            gv = (i % 2 == 0);
            step(1, gv, 1, (i < 8) ? (gv ? 3'b001 : 3'b010) : 3'b000);
        end
        chk("t3_level", level, 8);
        chk("t3_ovf", ovf, 1);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_head_mask", evt_mask, 3'b001);

        // Full: push and pop together keeps level, no new drop
        evt_ready = 1'b1;
        step(1, 0, 1, 3'b010);
        evt_ready = 1'b0;
        chk("t4_level", level, 8);
        chk("t4_ovf", ovf, 1);
        chk("t4_drop", drop_cnt, 1);
        evt_ready = 1'b1;
        repeat (10) step(1, 0, 1, 3'b000);
        chk("t4_drained", level, 0);
        chk("t4_empty_mask", evt_mask, 0);
        chk("t4_empty_ts", evt_ts, 0);
        chk("t4_queue", exp_q.size(), 0);

        // Saturation of the drop counter
        clr_ovf = 1'b1;
        step(1, 0, 1, 3'b000);
        clr_ovf = 1'b0;
        chk("t5_clr_ovf", ovf, 0);
        chk("t5_clr_drop", drop_cnt, 0);
        evt_ready = 1'b0;
        gv = 1'b0;
        for (int i = 0; i < 8 + 255; i++) begin
            gv = ~gv;
            step(1, gv, 1, (i < 8) ? (gv ? 3'b001 : 3'b010) : 3'b000);
        end
        chk("t5_drop_255", drop_cnt, 255);
        gv = ~gv;
        step(1, gv, 1, 3'b000);
        chk("t5_drop_sat", drop_cnt, 255);
        chk("t5_ovf", ovf, 1);
        clr_ovf = 1'b1;
        gv = ~gv;
        step(1, gv, 1, 3'b000);
        clr_ovf = 1'b0;
        chk("t5_clr_drop_wins_ovf", ovf, 1);
        chk("t5_clr_drop_wins_cnt", drop_cnt, 1);
        clr_ovf = 1'b1;
        step(1, gv, 1, 3'b000);
        clr_ovf = 1'b0;
        chk("t5_clr2_ovf", ovf, 0);
        chk("t5_clr2_drop", drop_cnt, 0);
        evt_ready = 1'b1;
        repeat (10) step(1, gv, 1, 3'b000);
        chk("t5_drained", level, 0);

        // Edge under en=0 is lost and not replayed
        evt_ready = 1'b0;
        step(0, 0, 1, 3'b000);
        step(0, 1, 1, 3'b000);
        step(1, 1, 1, 3'b000);
        step(1, 1, 1, 3'b000);
        chk("t6_no_replay_level", level, 0);
        chk("t6_no_replay_valid", evt_valid, 0);

        // Async reset with five records buffered
        step(1, 0, 1, 3'b010);
        step(1, 1, 1, 3'b001);
        step(1, 0, 1, 3'b010);
        step(1, 1, 1, 3'b001);
        step(1, 0, 1, 3'b010);
        chk("t6_level5", level, 5);
        rst = 1'b1;
        #1;
        chk("t6_rst_level", level, 0);
        chk("t6_rst_valid", evt_valid, 0);
        exp_q.delete();
        en = 1'b1; g = 1'b1; h = 1'b0; evt_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // g already high after release is a rise at ts 0
        step(1, 1, 0, 3'b001);
        repeat (3) step(1, 1, 0, 3'b000);
        chk("t6_post_rst_level", level, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
